// File: rtl/icache_req_arbiter.sv
// Request arbiter in front of the icache lookup pipeline: merges upstream reads and
// downstream snoops into one registered request, snoops first, with upstream anti-starvation.
module icache_req_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 4,
    parameter int TXNID_WIDTH  = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                up_vld,
    output logic                                up_rdy,
    input  logic [ADDR_WIDTH-1:0]               up_addr,
    input  logic [OPCODE_WIDTH-1:0]             up_opcode,
    input  logic [TXNID_WIDTH-1:0]              up_txnid,

    input  logic                                snp_vld,
    output logic                                snp_rdy,
    input  logic [ADDR_WIDTH-1:0]               snp_addr,
    input  logic [OPCODE_WIDTH-1:0]             snp_opcode,
    input  logic [TXNID_WIDTH-1:0]              snp_txnid,

    input  logic                                up_block,

    output logic                                pipe_vld,
    input  logic                                pipe_rdy,
    output logic [ADDR_WIDTH-1:0]               pipe_addr,
    output logic [OPCODE_WIDTH-1:0]             pipe_opcode,
    output logic [TXNID_WIDTH-1:0]              pipe_txnid,
    output logic                                pipe_src,

    output logic [$clog2(STARVE_LIMIT+1)-1:0]   starve_cnt
);

    localparam int                   CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic load_en;
    logic up_elig;
    logic starve_hit;
    logic grant_snp;
    logic grant_up;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        load_en    = !pipe_vld || pipe_rdy;
        up_elig    = up_vld && !up_block;
        starve_hit = up_elig && (starve_cnt == CNT_MAX);
        grant_snp  = 1'b0;
        grant_up   = 1'b0;
        if (rst_n && load_en) begin
            if (snp_vld && !starve_hit) begin
                grant_snp = 1'b1;
            end else if (up_elig) begin
                grant_up = 1'b1;
            end
        end
    end

    assign snp_rdy = grant_snp;
    assign up_rdy  = grant_up;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_up || !up_elig) begin
            starve_cnt <= '0;
        end else if (grant_snp && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    // Payload is only rewritten on a grant; an idle load just drops the valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld    <= 1'b0;
            pipe_src    <= 1'b0;
            pipe_addr   <= '0;
            pipe_opcode <= '0;
            pipe_txnid  <= '0;
        end else if (load_en) begin
            pipe_vld <= grant_snp || grant_up;
            if (grant_snp) begin
                pipe_src    <= 1'b1;
                pipe_addr   <= snp_addr;
                pipe_opcode <= snp_opcode;
                pipe_txnid  <= snp_txnid;
            end else if (grant_up) begin
                pipe_src    <= 1'b0;
                pipe_addr   <= up_addr;
                pipe_opcode <= up_opcode;
                pipe_txnid  <= up_txnid;
            end
        end
    end

    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(up_rdy && snp_rdy));

    a_hold_payload : assert property (@(posedge clk) disable iff (!rst_n)
        (pipe_vld && !pipe_rdy) |=> ($stable(pipe_addr) && $stable(pipe_opcode)
                                     && $stable(pipe_txnid) && $stable(pipe_src) && pipe_vld));

    a_block_masks_up : assert property (@(posedge clk) disable iff (!rst_n)
        up_block |-> !up_rdy);

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Self-checking bench for icache_req_arbiter: directed scenarios plus a constrained random run,
// all compared each cycle against a transaction-level model of the arbitration rules.
module tb_icache_req_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        up_vld, up_rdy, snp_vld, snp_rdy, up_block;
    logic [31:0] up_addr, snp_addr, pipe_addr;
    logic [3:0]  up_opcode, snp_opcode, pipe_opcode;
    logic [4:0]  up_txnid, snp_txnid, pipe_txnid;
    logic        pipe_vld, pipe_rdy, pipe_src;
    logic [2:0]  starve_cnt;

    icache_req_arbiter #(
        .ADDR_WIDTH(32), .OPCODE_WIDTH(4), .TXNID_WIDTH(5), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_vld(up_vld), .up_rdy(up_rdy), .up_addr(up_addr), .up_opcode(up_opcode),
        .up_txnid(up_txnid),
        .snp_vld(snp_vld), .snp_rdy(snp_rdy), .snp_addr(snp_addr), .snp_opcode(snp_opcode),
        .snp_txnid(snp_txnid),
        .up_block(up_block),
        .pipe_vld(pipe_vld), .pipe_rdy(pipe_rdy), .pipe_addr(pipe_addr),
        .pipe_opcode(pipe_opcode), .pipe_txnid(pipe_txnid), .pipe_src(pipe_src),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  op;
        logic [4:0]  id;
        logic        src;
    } req_t;

    // Model: requests accepted but not yet consumed by lookup, plus snoop wins since upstream last
    // got through (or stopped being eligible).
    req_t q[$];
    int   streak;
    int   up_wait;

    int n_checks = 0;
    int n_fail   = 0;

    // Values sampled from the DUT in the last step, before its edge.
    logic s_up_rdy, s_snp_rdy;
    logic [2:0] s_cnt;
    logic last_gu, last_gs;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        streak  = 0;
        up_wait = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic elig, load, gs, gu;
        req_t r;
        @(negedge clk);
        elig = up_vld && !up_block;
        load = (q.size() == 0) || pipe_rdy;
        gs   = load && snp_vld && !(elig && streak == LIMIT);
        gu   = load && !gs && elig;
        s_up_rdy  = up_rdy;
        s_snp_rdy = snp_rdy;
        s_cnt     = starve_cnt;
        check("up_rdy", 64'(up_rdy), 64'(gu));
        check("snp_rdy", 64'(snp_rdy), 64'(gs));
        check("pipe_vld", 64'(pipe_vld), 64'(q.size() != 0));
        check("starve_cnt", 64'(starve_cnt), 64'(streak));
        if (q.size() != 0) begin
            check("pipe_addr", 64'(pipe_addr), 64'(q[0].addr));
            check("pipe_opcode", 64'(pipe_opcode), 64'(q[0].op));
            check("pipe_txnid", 64'(pipe_txnid), 64'(q[0].id));
            check("pipe_src", 64'(pipe_src), 64'(q[0].src));
        end
        @(posedge clk);
        if (q.size() != 0 && pipe_rdy) void'(q.pop_front());
        if (gs) begin
            r = '{snp_addr, snp_opcode, snp_txnid, 1'b1};
            q.push_back(r);
        end
        if (gu) begin
            r = '{up_addr, up_opcode, up_txnid, 1'b0};
            q.push_back(r);
        end
        if (gu || !elig) streak = 0;
        else if (gs && streak < LIMIT) streak++;
        // Fairness: an unblocked upstream request never sees more than LIMIT snoop grants first.
        if (gu) begin
            check("up_wait", 64'(up_wait <= LIMIT), 64'(1));
            up_wait = 0;
        end else if (!up_vld || up_block) begin
            up_wait = 0;
        end else if (gs) begin
            up_wait++;
        end
        last_gu = gu;
        last_gs = gs;
        #1;
    endtask

    int   exp_cnt[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    logic exp_up[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        model_reset();
        rst_n = 1'b0;
        up_vld = 1'b1; snp_vld = 1'b1; up_block = 1'b0; pipe_rdy = 1'b1;
        up_addr = 32'h0000_1000; up_opcode = 4'h2; up_txnid = 5'd1;
        snp_addr = 32'hABCD_0040; snp_opcode = 4'h9; snp_txnid = 5'd17;

        // Reset held with both requesters valid.
        @(negedge clk);
        check("rst_up_rdy", 64'(up_rdy), 64'(0));
        check("rst_snp_rdy", 64'(snp_rdy), 64'(0));
        check("rst_pipe_vld", 64'(pipe_vld), 64'(0));
        check("rst_cnt", 64'(starve_cnt), 64'(0));
        check("rst_pipe_src", 64'(pipe_src), 64'(0));
        check("rst_pipe_addr", 64'(pipe_addr), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First grant after reset goes to the snoop.
        step();
        check("first_grant_snp", 64'(s_snp_rdy), 64'(1));
        check("first_pipe_src", 64'(pipe_src), 64'(1));
        check("first_pipe_addr", 64'(pipe_addr), 64'h0000_0000_ABCD_0040);

        // Single upstream request.
        snp_vld = 1'b0;
        up_addr = 32'h0001_23FF; up_txnid = 5'd3; up_opcode = 4'h1;
        step();
        check("single_up_rdy", 64'(s_up_rdy), 64'(1));
        check("single_pipe_vld", 64'(pipe_vld), 64'(1));
        check("single_pipe_addr", 64'(pipe_addr), 64'h0000_0000_0001_23FF);
        check("single_pipe_txnid", 64'(pipe_txnid), 64'(3));
        check("single_pipe_src", 64'(pipe_src), 64'(0));
        up_vld = 1'b0;
        step();
        check("single_up_once", 64'(s_up_rdy), 64'(0));

        // Starvation: both held valid with the lookup always ready.
        up_vld = 1'b1; snp_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("starve_up_%0d", i), 64'(s_up_rdy), 64'(exp_up[i]));
            check($sformatf("starve_snp_%0d", i), 64'(s_snp_rdy), 64'(!exp_up[i]));
            check($sformatf("starve_cnt_%0d", i), 64'(s_cnt), 64'(exp_cnt[i]));
        end

        // Backpressure: upstream request is parked in the register, nothing is granted.
        pipe_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_up_rdy_%0d", i), 64'(s_up_rdy), 64'(0));
            check($sformatf("bp_snp_rdy_%0d", i), 64'(s_snp_rdy), 64'(0));
            check($sformatf("bp_addr_%0d", i), 64'(pipe_addr), 64'h0000_0000_0001_23FF);
            check($sformatf("bp_src_%0d", i), 64'(pipe_src), 64'(0));
        end
        pipe_rdy = 1'b1;
        step();
        check("bp_release_snp", 64'(s_snp_rdy), 64'(1));

        // up_block: upstream masked, count clears, snoops still flow.
        up_block = 1'b1;
        for (int i = 0; i < 6; i++) begin
            snp_vld = (i % 2 == 0);
            step();
            check($sformatf("blk_up_rdy_%0d", i), 64'(s_up_rdy), 64'(0));
            check($sformatf("blk_snp_rdy_%0d", i), 64'(s_snp_rdy), 64'(i % 2 == 0));
            check($sformatf("blk_cnt_%0d", i), 64'(s_cnt), 64'(i == 0 ? 1 : 0));
        end
        up_block = 1'b0; snp_vld = 1'b0;
        step();
        check("unblock_up_rdy", 64'(s_up_rdy), 64'(1));

        // Reset while a request sits in the register.
        up_vld = 1'b0; snp_vld = 1'b1; pipe_rdy = 1'b0;
        step();
        check("mid_pipe_vld", 64'(pipe_vld), 64'(1));
        rst_n = 1'b0;
        #2;
        check("mid_rst_pipe_vld", 64'(pipe_vld), 64'(0));
        check("mid_rst_snp_rdy", 64'(snp_rdy), 64'(0));
        check("mid_rst_cnt", 64'(starve_cnt), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic honouring hold-until-ready on both requesters.
        last_gu = 1'b1; last_gs = 1'b1; up_vld = 1'b0; snp_vld = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!up_vld || last_gu) begin
                up_vld    = ($urandom_range(0, 3) != 0);
                up_addr   = $urandom;
                up_opcode = 4'($urandom);
                up_txnid  = 5'($urandom);
            end
            if (!snp_vld || last_gs) begin
                snp_vld    = ($urandom_range(0, 2) == 0);
                snp_addr   = $urandom;
                snp_opcode = 4'($urandom);
                snp_txnid  = 5'($urandom);
            end
            up_block = ($urandom_range(0, 7) == 0);
            pipe_rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
